// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-source result FIFOs drained one entry per cycle
// by round-robin onto a registered CDB write port. Tag 0 is never broadcast.
module cdb_arbiter #(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned TAG_W   = 4,
   parameter int unsigned DEPTH   = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic [NUM_SRC-1:0]       src_vld,
   output logic [NUM_SRC-1:0]       src_rdy,
   input  logic [NUM_SRC*TAG_W-1:0] src_tag,
   input  logic [NUM_SRC*32-1:0]    src_wdata,
   output logic                     cdb_wr,
   output logic [TAG_W-1:0]         cdb_tag,
   output logic [31:0]              cdb_wdata,
   output logic                     err_tag0,
   output logic [31:0]              bcast_cnt
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned SEL_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [TAG_W-1:0]  tag_mem   [NUM_SRC][DEPTH];
   logic [DATA_W-1:0] data_mem  [NUM_SRC][DEPTH];
   logic [PTR_W-1:0]  rd_ptr    [NUM_SRC];
   logic [PTR_W-1:0]  wr_ptr    [NUM_SRC];
   logic [CNT_W-1:0]  count     [NUM_SRC];
   logic [CNT_W-1:0]  count_nxt [NUM_SRC];

   logic [NUM_SRC-1:0] non_empty;
   logic [NUM_SRC-1:0] push;
   logic [NUM_SRC-1:0] wr_en;
   logic [NUM_SRC-1:0] pop;
   logic [NUM_SRC-1:0] tag0_hit;

   logic [SEL_W-1:0]  rr_ptr;
   logic [SEL_W-1:0]  rr_next;
   logic [SEL_W-1:0]  gnt;
   logic [SEL_W-1:0]  cand;
   logic              gnt_vld;
   logic [TAG_W-1:0]  head_tag;
   logic [DATA_W-1:0] head_data;

   // Handshake decode; tag-0 pushes complete the handshake but are not stored
   always_comb begin
      non_empty = '0;
      push      = '0;
      tag0_hit  = '0;
      wr_en     = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         non_empty[i] = (count[i] != '0);
         push[i]      = src_vld[i] && src_rdy[i] && !flush;
         tag0_hit[i]  = push[i] && (src_tag[i*TAG_W +: TAG_W] == '0);
         wr_en[i]     = push[i] && !tag0_hit[i];
      end
   end

   // Round-robin search starting at rr_ptr
   always_comb begin
      gnt_vld = 1'b0;
      gnt     = '0;
      cand    = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         cand = SEL_W'((int'(rr_ptr) + k) % int'(NUM_SRC));
         if (!gnt_vld && non_empty[cand]) begin
            gnt_vld = 1'b1;
            gnt     = cand;
         end
      end
   end

   assign head_tag  = tag_mem[gnt][rd_ptr[gnt]];
   assign head_data = data_mem[gnt][rd_ptr[gnt]];
   assign rr_next   = (gnt == SEL_W'(NUM_SRC - 1)) ? '0 : gnt + SEL_W'(1);

   // Pop selection and next occupancy
   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         pop[i]       = gnt_vld && !flush && (gnt == SEL_W'(i));
         count_nxt[i] = flush ? '0 : count[i] + CNT_W'(wr_en[i]) - CNT_W'(pop[i]);
      end
   end

   // FIFO pointers, occupancy and registered ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            count[i]  <= '0;
         end
         src_rdy <= '1;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            count[i]   <= count_nxt[i];
            src_rdy[i] <= (count_nxt[i] < CNT_W'(DEPTH));
            if (flush) begin
               rd_ptr[i] <= '0;
               wr_ptr[i] <= '0;
            end else begin
               if (pop[i])   rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
               if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
            end
         end
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (wr_en[i]) begin
            tag_mem[i][wr_ptr[i]]  <= src_tag[i*TAG_W +: TAG_W];
            data_mem[i][wr_ptr[i]] <= src_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Registered CDB port, round-robin pointer and status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cdb_wr    <= 1'b0;
         cdb_tag   <= '0;
         cdb_wdata <= '0;
         rr_ptr    <= '0;
         bcast_cnt <= '0;
         err_tag0  <= 1'b0;
      end else begin
         if (|tag0_hit) err_tag0 <= 1'b1;
         if (flush) begin
            cdb_wr    <= 1'b0;
            cdb_tag   <= '0;
            cdb_wdata <= '0;
            rr_ptr    <= '0;
         end else if (gnt_vld) begin
            cdb_wr    <= 1'b1;
            cdb_tag   <= head_tag;
            cdb_wdata <= head_data;
            rr_ptr    <= rr_next;
            bcast_cnt <= bcast_cnt + 32'd1;
         end else begin
            cdb_wr    <= 1'b0;
            cdb_tag   <= '0;
            cdb_wdata <= '0;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_cdb_arbiter;

   localparam int unsigned NS = 4;
   localparam int unsigned TW = 4;
   localparam int unsigned DP = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush = 1'b0;
   logic [NS-1:0]     src_vld = '0;
   logic [NS-1:0]     src_rdy;
   logic [NS*TW-1:0]  src_tag = '0;
   logic [NS*32-1:0]  src_wdata = '0;
   logic              cdb_wr;
   logic [TW-1:0]     cdb_tag;
   logic [31:0]       cdb_wdata;
   logic              err_tag0;
   logic [31:0]       bcast_cnt;

   cdb_arbiter #(.NUM_SRC(NS), .TAG_W(TW), .DEPTH(DP)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .src_vld(src_vld), .src_rdy(src_rdy), .src_tag(src_tag), .src_wdata(src_wdata),
      .cdb_wr(cdb_wr), .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata),
      .err_tag0(err_tag0), .bcast_cnt(bcast_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Reference model: plain per-source queues
   logic [TW-1:0] mq_tag [NS][$];
   logic [31:0]   mq_dat [NS][$];
   int            m_rr;
   logic          m_wr;
   logic [TW-1:0] m_tag;
   logic [31:0]   m_wd;
   logic          m_err;
   logic [31:0]   m_cnt;

   logic [NS-1:0] d_vld = '0;
   logic [TW-1:0] d_tag [NS];
   logic [31:0]   d_wd  [NS];
   logic [NS-1:0] acc = '0;
   logic          bp_mode = 1'b0;
   logic [TW-1:0] seen0 [$];

   task automatic model_reset();
      for (int i = 0; i < NS; i++) begin
         mq_tag[i].delete();
         mq_dat[i].delete();
      end
      m_rr = 0; m_wr = 1'b0; m_tag = '0; m_wd = '0; m_err = 1'b0; m_cnt = '0;
   endtask

   task automatic drive_all(input logic fl);
      flush   = fl;
      src_vld = d_vld;
      for (int i = 0; i < NS; i++) begin
         src_tag[i*TW +: TW]   = d_tag[i];
         src_wdata[i*32 +: 32] = d_wd[i];
      end
   endtask

   // One cycle: called at a negedge, advances to the next negedge and checks
   task automatic tick(input logic fl);
      logic [NS-1:0] rdy_e;
      int w;
      drive_all(fl);
      for (int i = 0; i < NS; i++) rdy_e[i] = (mq_tag[i].size() < DP);
      chk("src_rdy", 64'(src_rdy), 64'(rdy_e));
      acc = '0;
      if (fl) begin
         for (int i = 0; i < NS; i++) begin
            mq_tag[i].delete();
            mq_dat[i].delete();
         end
         m_rr = 0; m_wr = 1'b0; m_tag = '0; m_wd = '0;
      end else begin
         w = -1;
         for (int k = 0; k < NS; k++) begin
            int j;
            j = (m_rr + k) % NS;
            if (w < 0 && mq_tag[j].size() > 0) w = j;
         end
         if (w >= 0) begin
            m_wr = 1'b1;
            m_tag = mq_tag[w].pop_front();
            m_wd  = mq_dat[w].pop_front();
            m_cnt = m_cnt + 32'd1;
            m_rr  = (w + 1) % NS;
         end else begin
            m_wr = 1'b0; m_tag = '0; m_wd = '0;
         end
         for (int i = 0; i < NS; i++) begin
            if (d_vld[i] && rdy_e[i]) begin
               acc[i] = 1'b1;
               if (d_tag[i] == '0) m_err = 1'b1;
               else begin
                  mq_tag[i].push_back(d_tag[i]);
                  mq_dat[i].push_back(d_wd[i]);
               end
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      chk("cdb_wr", 64'(cdb_wr), 64'(m_wr));
      chk("cdb_tag", 64'(cdb_tag), 64'(m_tag));
      chk("cdb_wdata", 64'(cdb_wdata), 64'(m_wd));
      chk("err_tag0", 64'(err_tag0), 64'(m_err));
      chk("bcast_cnt", 64'(bcast_cnt), 64'(m_cnt));
      if (bp_mode && cdb_wr && cdb_tag < 4'd4) seen0.push_back(cdb_tag);
   endtask

   typedef struct {
      logic [3:0]  vld;
      logic [15:0] tags;
      logic [31:0] wd;
      logic        fl;
      logic        ewr;
      logic [3:0]  etag;
      logic [31:0] ewd;
      logic [3:0]  erdy;
      logic        eerr;
      logic [31:0] ecnt;
   } vec_t;

   vec_t tbl [20];

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic saw_bp;
      int   p0;
      for (int i = 0; i < NS; i++) begin d_tag[i] = '0; d_wd[i] = '0; end
      model_reset();

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_cdb_wr", 64'(cdb_wr), 64'd0);
      chk("rst_cdb_tag", 64'(cdb_tag), 64'd0);
      chk("rst_cdb_wdata", 64'(cdb_wdata), 64'd0);
      chk("rst_err", 64'(err_tag0), 64'd0);
      chk("rst_cnt", 64'(bcast_cnt), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_rdy", 64'(src_rdy), 64'hF);

      // Directed table: expectations are values seen after the row's edge
      tbl[0]  = '{4'b0010, 16'h0050, 32'hDEADBEEF, 1'b0, 1'b0, 4'd0, 32'h0,        4'hF, 1'b0, 32'd0};
      tbl[1]  = '{4'b0000, 16'h0000, 32'h0,        1'b0, 1'b1, 4'd5, 32'hDEADBEEF, 4'hF, 1'b0, 32'd1};
      tbl[2]  = '{4'b0000, 16'h0000, 32'h0,        1'b0, 1'b0, 4'd0, 32'h0,        4'hF, 1'b0, 32'd1};
      tbl[3]  = '{4'b0000, 16'h0000, 32'h0,        1'b1, 1'b0, 4'd0, 32'h0,        4'hF, 1'b0, 32'd1};
      tbl[4]  = '{4'b1111, 16'h4321, 32'hA0,       1'b0, 1'b0, 4'd0, 32'h0,        4'hF, 1'b0, 32'd1};
      tbl[5]  = '{4'b0000, 16'h0000, 32'h0,        1'b0, 1'b1, 4'd1, 32'hA0,       4'hF, 1'b0, 32'd2};
      tbl[6]  = '{4'b0000, 16'h0000, 32'h0,        1'b0, 1'b1, 4'd2, 32'hA0,       4'hF, 1'b0, 32'd3};
      tbl[7]  = '{4'b0000, 16'h0000, 32'h0,        1'b0, 1'b1, 4'd3, 32'hA0,       4'hF, 1'b0, 32'd4};
      tbl[8]  = '{4'b0000, 16'h0000, 32'h0,        1'b0, 1'b1, 4'd4, 32'hA0,       4'hF, 1'b0, 32'd5};
      tbl[9]  = '{4'b0000, 16'h0000, 32'h0,        1'b0, 1'b0, 4'd0, 32'h0,        4'hF, 1'b0, 32'd5};
      tbl[10] = '{4'b0100, 16'h0000, 32'h0,        1'b0, 1'b0, 4'd0, 32'h0,        4'hF, 1'b1, 32'd5};
      tbl[11] = '{4'b0100, 16'h0700, 32'h77,       1'b0, 1'b0, 4'd0, 32'h0,        4'hF, 1'b1, 32'd5};
      tbl[12] = '{4'b0000, 16'h0000, 32'h0,        1'b0, 1'b1, 4'd7, 32'h77,       4'hF, 1'b1, 32'd6};
      tbl[13] = '{4'b0000, 16'h0000, 32'h0,        1'b0, 1'b0, 4'd0, 32'h0,        4'hF, 1'b1, 32'd6};
      tbl[14] = '{4'b1011, 16'h3021, 32'h55,       1'b0, 1'b0, 4'd0, 32'h0,        4'hF, 1'b1, 32'd6};
      tbl[15] = '{4'b0100, 16'h0600, 32'h66,       1'b1, 1'b0, 4'd0, 32'h0,        4'hF, 1'b1, 32'd6};
      tbl[16] = '{4'b0000, 16'h0000, 32'h0,        1'b0, 1'b0, 4'd0, 32'h0,        4'hF, 1'b1, 32'd6};
      tbl[17] = '{4'b0100, 16'h0900, 32'h99,       1'b0, 1'b0, 4'd0, 32'h0,        4'hF, 1'b1, 32'd6};
      tbl[18] = '{4'b0000, 16'h0000, 32'h0,        1'b0, 1'b1, 4'd9, 32'h99,       4'hF, 1'b1, 32'd7};
      tbl[19] = '{4'b0000, 16'h0000, 32'h0,        1'b0, 1'b0, 4'd0, 32'h0,        4'hF, 1'b1, 32'd7};

      @(negedge clk);
      for (int r = 0; r < 20; r++) begin
         d_vld = tbl[r].vld;
         for (int i = 0; i < NS; i++) begin
            d_tag[i] = tbl[r].tags[i*TW +: TW];
            d_wd[i]  = tbl[r].wd;
         end
         drive_all(tbl[r].fl);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("tbl%0d_wr", r),   64'(cdb_wr),    64'(tbl[r].ewr));
         chk($sformatf("tbl%0d_tag", r),  64'(cdb_tag),   64'(tbl[r].etag));
         chk($sformatf("tbl%0d_data", r), 64'(cdb_wdata), 64'(tbl[r].ewd));
         chk($sformatf("tbl%0d_rdy", r),  64'(src_rdy),   64'(tbl[r].erdy));
         chk($sformatf("tbl%0d_err", r),  64'(err_tag0),  64'(tbl[r].eerr));
         chk($sformatf("tbl%0d_cnt", r),  64'(bcast_cnt), 64'(tbl[r].ecnt));
      end
      d_vld = '0;
      drive_all(1'b0);

      // Clean restart for the model-checked phases
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Backpressure: sources 1-3 saturated, source 0 sends tags 1,2,3
      bp_mode = 1'b1;
      saw_bp  = 1'b0;
      p0      = 0;
      for (int cyc = 0; cyc < 60 && seen0.size() < 3; cyc++) begin
         for (int i = 1; i < NS; i++) begin
            d_vld[i] = 1'b1;
            d_tag[i] = TW'(8 + i);
            d_wd[i]  = 32'h1000 + 32'(i);
         end
         d_vld[0] = (cyc >= 1) && (p0 < 3);
         d_tag[0] = TW'(p0 + 1);
         d_wd[0]  = 32'h100 + 32'(p0);
         if (d_vld[0] && !src_rdy[0]) saw_bp = 1'b1;
         tick(1'b0);
         if (acc[0]) p0++;
      end
      bp_mode = 1'b0;
      chk("bp_src0_stalled", 64'(saw_bp), 64'd1);
      chk("bp_order_len", 64'(seen0.size()), 64'd3);
      for (int k = 0; k < 3; k++) begin
         if (k < seen0.size()) chk($sformatf("bp_order%0d", k), 64'(seen0[k]), 64'(k + 1));
      end
      d_vld = '0;
      repeat (8) tick(1'b0);

      // Randomized traffic; a stalled source holds its values
      for (int n = 0; n < 500; n++) begin
         for (int i = 0; i < NS; i++) begin
            if (!(d_vld[i] && !acc[i])) begin
               d_vld[i] = 1'($urandom_range(0, 1));
               d_tag[i] = TW'($urandom_range(0, 15));
               d_wd[i]  = $urandom;
            end
         end
         tick($urandom_range(0, 39) == 0);
      end
      d_vld = '0;
      repeat (6) tick(1'b0);

      // Asynchronous reset while a result is on the bus
      d_vld[1] = 1'b1; d_tag[1] = TW'(5); d_wd[1] = 32'hCAFE0001;
      d_vld[3] = 1'b1; d_tag[3] = TW'(6); d_wd[3] = 32'hCAFE0003;
      tick(1'b0);
      d_vld = '0;
      tick(1'b0);
      chk("ar_pre_wr", 64'(cdb_wr), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_wr", 64'(cdb_wr), 64'd0);
      chk("ar_tag", 64'(cdb_tag), 64'd0);
      chk("ar_data", 64'(cdb_wdata), 64'd0);
      chk("ar_cnt", 64'(bcast_cnt), 64'd0);
      chk("ar_err", 64'(err_tag0), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (3) tick(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
